// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_pkg
// Description : Shared definitions for the multi-channel input PIO bank:
//               register offsets derived from the channel count, CTRL bit
//               positions, register-select decode and parameter checks.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_pkg;

  // Width of the Avalon data path; channel words are zero-extended to this.
  localparam int BUS_W = 32;

  // CTRL register bit positions.
  localparam int CTRL_FREEZE_BIT = 0;
  localparam int CTRL_SNAP_BIT   = 1;
  localparam int CTRL_PRIMED_BIT = 2;

  // Register groups addressed by the word address.
  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_CTRL   = 3'd1,
    REG_CHANGE = 3'd2,
    REG_MASK   = 3'd3,
    REG_NONE   = 3'd4
  } reg_sel_e;

  // Control/status registers sit directly above the channel data words.
  function automatic int ctrl_ofs(input int num_ch);
    return num_ch;
  endfunction

  function automatic int change_ofs(input int num_ch);
    return num_ch + 1;
  endfunction

  function automatic int mask_ofs(input int num_ch);
    return num_ch + 2;
  endfunction

  function automatic reg_sel_e decode_addr(input int addr, input int num_ch);
    if (addr < num_ch)                  return REG_DATA;
    else if (addr == ctrl_ofs(num_ch))   return REG_CTRL;
    else if (addr == change_ofs(num_ch)) return REG_CHANGE;
    else if (addr == mask_ofs(num_ch))   return REG_MASK;
    else                                 return REG_NONE;
  endfunction

  // Legal channel width.
  function automatic bit data_w_ok(input int data_w);
    return (data_w >= 1) && (data_w <= BUS_W);
  endfunction

  // The map needs NUM_CH data words plus three control words, and the
  // per-channel CHANGE/MASK bits must fit inside one bus word.
  function automatic bit map_fits(input int num_ch, input int addr_w);
    return (num_ch >= 1) && (num_ch <= BUS_W) &&
           ((num_ch + 3) <= (1 << addr_w));
  endfunction

endpackage : pio_pkg
`default_nettype wire

// File: rtl/pio_in_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : pio_in_bank_if
// Description : Avalon-MM slave bus bundle for the input PIO bank
//               (word address, single-cycle write strobe, write data and
//               registered read data; no read strobe).
// Ports       : address   - word address, ADDR_W bits
//               write     - write strobe
//               writedata - 32-bit write data
//               readdata  - 32-bit read data driven by the slave
// Revision    : 1.0 - initial release
// ============================================================================
interface pio_in_bank_if #(
  parameter int ADDR_W = 3
) ();

  logic [ADDR_W-1:0] address;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    output readdata
  );

endinterface : pio_in_bank_if
`default_nettype wire

// File: rtl/pio_sync_bus.sv
`default_nettype none
// ============================================================================
// Module      : pio_sync_bus
// Description : Per-bit N-stage flop synchroniser over a WIDTH-bit bus with
//               asynchronous active-low reset. STAGES = 0 passes the input
//               straight through for sources already in the clk domain.
//               No gray coding: multi-bit coherence is up to the producer.
// Ports       : clk     - destination clock
//               reset_n - asynchronous active-low reset (all stages to 0)
//               d_i     - asynchronous input bus
//               q_o     - synchronised bus
// Revision    : 1.0 - initial release
// ============================================================================
module pio_sync_bus #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic [WIDTH-1:0] d_i,
  output logic      [WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    // Clock and reset have no job in bypass mode.
    logic unused_bypass;
    assign unused_bypass = clk ^ reset_n;
    assign q_o           = d_i;
  end else begin : g_sync
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < STAGES; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[STAGES-1];
  end

endmodule : pio_sync_bus
`default_nettype wire

// File: rtl/pio_in_bank.sv
`default_nettype none
// ============================================================================
// Module      : pio_in_bank
// Description : Multi-channel Avalon-MM input PIO. NUM_CH words of DATA_W
//               bits are synchronised into clk. Adds per-channel change
//               detection (RW1C CHANGE register, maskable level interrupt)
//               and a coherent snapshot of all channels for frozen reads.
//
//               Register map (word offsets):
//                 0..NUM_CH-1 DATA[k]  RO  snapshot if freeze else live value
//                 NUM_CH      CTRL     bit0 freeze RW, bit1 snap W1 strobe,
//                                      bit2 primed RO
//                 NUM_CH+1    CHANGE   RW1C, set has priority over clear
//                 NUM_CH+2    IRQ_MASK RW, NUM_CH bits
//                 others      read 0, writes ignored
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               bus      - Avalon-MM slave (address/write/writedata/readdata)
//               in_port  - channel k at bits [k*DATA_W +: DATA_W]
//               irq      - registered level interrupt |(CHANGE & IRQ_MASK)
// Revision    : 1.0 - initial release
// ============================================================================
module pio_in_bank
  import pio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  pio_in_bank_if.slave                  bus,
  input  wire logic [NUM_CH*DATA_W-1:0] in_port,
  output logic                          irq
);

  // --------------------------------------------------------------------------
  // Parameter checks
  // --------------------------------------------------------------------------
  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("pio_in_bank: DATA_W must be in 1..32");
  end

  if (!map_fits(NUM_CH, ADDR_W)) begin : g_bad_map
    $error("pio_in_bank: NUM_CH+3 must fit in 2**ADDR_W words (and NUM_CH <= 32)");
  end

  localparam int BANK_W = NUM_CH * DATA_W;

  // Priming counts SYNC_STAGES+1 edges after reset and then saturates.
  localparam int                CNT_W      = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  PRIME_DONE = CNT_W'(SYNC_STAGES + 1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [BANK_W-1:0] synced;

  pio_sync_bus #(
    .WIDTH  (BANK_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (in_port),
    .q_o     (synced)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]  prime_cnt_q,  prime_cnt_d;
  logic [BANK_W-1:0] prev_q,       prev_d;
  logic [BANK_W-1:0] snap_q,       snap_d;
  logic              freeze_q,     freeze_d;
  logic [NUM_CH-1:0] change_q,     change_d;
  logic [NUM_CH-1:0] mask_q,       mask_d;
  logic              irq_q,        irq_d;
  logic [BUS_W-1:0]  readdata_q,   readdata_d;

  logic              primed;
  logic [NUM_CH-1:0] change_set;
  logic [NUM_CH-1:0] change_clr;
  logic [BANK_W-1:0] data_view;
  reg_sel_e          sel;
  int                addr_int;
  logic              wr_ctrl;
  logic              wr_change;
  logic              wr_mask;

  // Upper write-data bits only matter for the narrower registers.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  assign primed   = (prime_cnt_q == PRIME_DONE);
  assign addr_int = int'(bus.address);
  assign sel      = decode_addr(addr_int, NUM_CH);

  assign wr_ctrl   = bus.write && (sel == REG_CTRL);
  assign wr_change = bus.write && (sel == REG_CHANGE);
  assign wr_mask   = bus.write && (sel == REG_MASK);

  // Frozen reads come from the snapshot; otherwise from the live synced bus.
  assign data_view = freeze_q ? snap_q : synced;

  // --------------------------------------------------------------------------
  // Per-channel change detection. prev tracks synced every cycle, including
  // during priming, so the reset-to-data transition is absorbed silently.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign change_set[k] = primed &&
        (synced[k*DATA_W +: DATA_W] != prev_q[k*DATA_W +: DATA_W]);
  end

  assign change_clr = wr_change ? bus.writedata[NUM_CH-1:0] : '0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    prime_cnt_d = prime_cnt_q;
    prev_d      = synced;
    snap_d      = snap_q;
    freeze_d    = freeze_q;
    change_d    = change_q;
    mask_d      = mask_q;
    irq_d       = |(change_q & mask_q);

    if (!primed) begin
      prime_cnt_d = prime_cnt_q + CNT_W'(1);
    end

    // A set in the same cycle as a W1C clear must survive.
    change_d = (change_q & ~change_clr) | change_set;

    if (wr_mask) begin
      mask_d = bus.writedata[NUM_CH-1:0];
    end

    if (wr_ctrl) begin
      freeze_d = bus.writedata[CTRL_FREEZE_BIT];
      // The snapshot captures the bus as it is this cycle, independent of
      // freeze, so freeze+snap in one write yields a coherent frozen view.
      if (bus.writedata[CTRL_SNAP_BIT]) begin
        snap_d = synced;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: uses pre-write register state for the address sampled this
  // edge; there is no read strobe, so readdata refreshes every cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    readdata_d = '0;
    case (sel)
      REG_DATA: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (addr_int == k) begin
            readdata_d = BUS_W'(data_view[k*DATA_W +: DATA_W]);
          end
        end
      end
      REG_CTRL: begin
        readdata_d[CTRL_FREEZE_BIT] = freeze_q;
        readdata_d[CTRL_PRIMED_BIT] = primed;
      end
      REG_CHANGE: readdata_d = BUS_W'(change_q);
      REG_MASK:   readdata_d = BUS_W'(mask_q);
      default:    readdata_d = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt_q <= '0;
      prev_q      <= '0;
      snap_q      <= '0;
      freeze_q    <= 1'b0;
      change_q    <= '0;
      mask_q      <= '0;
      irq_q       <= 1'b0;
      readdata_q  <= '0;
    end else begin
      prime_cnt_q <= prime_cnt_d;
      prev_q      <= prev_d;
      snap_q      <= snap_d;
      freeze_q    <= freeze_d;
      change_q    <= change_d;
      mask_q      <= mask_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule : pio_in_bank
`default_nettype wire

// File: tb/tb_pio_in_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_in_bank
// Description : Self-checking bench for pio_in_bank. A behavioural model
//               built from a history queue of sampled inputs predicts
//               readdata and irq on every clock; register-access vectors,
//               hand-written latency/corner sequences and a randomised phase
//               drive the DUT. A second DUT with DATA_W=12 covers
//               zero-extension.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_in_bank;

  localparam int DW   = 32;
  localparam int NC   = 4;
  localparam int AW   = 3;
  localparam int SS   = 2;
  localparam int CTRL = NC;
  localparam int CHG  = NC + 1;
  localparam int MSK  = NC + 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [NC*DW-1:0] in_port;
  logic             irq;
  logic [4*12-1:0]  in12;
  logic             irq12;

  pio_in_bank_if #(.ADDR_W(AW)) bus ();
  pio_in_bank_if #(.ADDR_W(AW)) bus12 ();

  pio_in_bank #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  pio_in_bank #(.DATA_W(12), .NUM_CH(4), .ADDR_W(AW), .SYNC_STAGES(SS)) dut12 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus12.slave),
    .in_port (in12),
    .irq     (irq12)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model state ----------------
  logic [NC*DW-1:0] m_hist[$];   // in_port as sampled at each edge, newest first
  logic [NC*DW-1:0] m_prev;      // synced value one edge earlier
  logic [NC*DW-1:0] m_snap;
  logic             m_freeze;
  logic [NC-1:0]    m_change;
  logic [NC-1:0]    m_mask;
  int               m_edges;     // edges since reset release

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_prev   = '0;
    m_snap   = '0;
    m_freeze = 1'b0;
    m_change = '0;
    m_mask   = '0;
    m_edges  = 0;
  endtask

  // Synced value = input sampled SS edges ago (zero before enough samples).
  function automatic logic [NC*DW-1:0] m_synced();
    if (SS == 0) return in_port;
    if (m_hist.size() >= SS) return m_hist[SS-1];
    return '0;
  endfunction

  function automatic logic [31:0] m_read(input int a, input logic [NC*DW-1:0] syn);
    logic [31:0] r;
    r = '0;
    if (a < NC) r = m_freeze ? m_snap[a*DW +: DW] : syn[a*DW +: DW];
    else if (a == CTRL) r = {29'd0, (m_edges >= SS + 1), 1'b0, m_freeze};
    else if (a == CHG)  r = {28'd0, m_change};
    else if (a == MSK)  r = {28'd0, m_mask};
    return r;
  endfunction

  // One clock: predict from pre-edge state, advance the model, compare.
  task automatic tick();
    logic [NC*DW-1:0] syn;
    logic [31:0]      rd_exp;
    logic             irq_exp;
    logic [NC-1:0]    set_v;
    logic [NC-1:0]    clr_v;
    int               a;
    a       = int'(bus.address);
    syn     = m_synced();
    rd_exp  = m_read(a, syn);
    irq_exp = |(m_change & m_mask);
    set_v   = '0;
    if (m_edges >= SS + 1) begin
      for (int k = 0; k < NC; k++) begin
        if (syn[k*DW +: DW] != m_prev[k*DW +: DW]) set_v[k] = 1'b1;
      end
    end
    clr_v = (bus.write && a == CHG) ? bus.writedata[NC-1:0] : '0;
    if (bus.write && a == MSK) m_mask = bus.writedata[NC-1:0];
    if (bus.write && a == CTRL) begin
      m_freeze = bus.writedata[0];
      if (bus.writedata[1]) m_snap = syn;
    end
    m_change = (m_change & ~clr_v) | set_v;
    m_prev   = syn;
    m_hist.push_front(in_port);
    if (m_hist.size() > 4) void'(m_hist.pop_back());
    m_edges++;
    @(posedge clk);
    #1;
    check("model_readdata", bus.readdata, rd_exp);
    check("model_irq", {31'd0, irq}, {31'd0, irq_exp});
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.address   = AW'(a);
    bus.write     = 1'b1;
    bus.writedata = d;
    tick();
    bus.write     = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    bus.address = AW'(a);
    bus.write   = 1'b0;
    tick();
    d = bus.readdata;
  endtask

  typedef struct {
    int          addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] d;

    tbl[0]  = '{MSK,  1'b1, 32'hFFFF_FFFF, 32'h0};
    tbl[1]  = '{MSK,  1'b0, 32'h0,         32'h0000_000F};
    tbl[2]  = '{MSK,  1'b1, 32'h0000_0002, 32'h0};
    tbl[3]  = '{MSK,  1'b0, 32'h0,         32'h0000_0002};
    tbl[4]  = '{CTRL, 1'b1, 32'h0000_0007, 32'h0};
    tbl[5]  = '{CTRL, 1'b0, 32'h0,         32'h0000_0005};
    tbl[6]  = '{CTRL, 1'b1, 32'h0000_0000, 32'h0};
    tbl[7]  = '{CTRL, 1'b0, 32'h0,         32'h0000_0004};
    tbl[8]  = '{7,    1'b1, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{7,    1'b0, 32'h0,         32'h0000_0000};
    tbl[10] = '{0,    1'b1, 32'h1234_5678, 32'h0};
    tbl[11] = '{0,    1'b0, 32'h0,         32'hDEAD_BEEF};
    tbl[12] = '{1,    1'b0, 32'h0,         32'h0000_0000};
    tbl[13] = '{CHG,  1'b0, 32'h0,         32'h0000_0000};

    // ---------------- reset state ----------------
    reset_n         = 1'b0;
    in_port         = '0;
    in_port[31:0]   = 32'hDEAD_BEEF;
    in12            = {12'hABC, 12'h000, 12'h000, 12'hFFF};
    bus.address     = '0;
    bus.write       = 1'b0;
    bus.writedata   = '0;
    bus12.address   = '0;
    bus12.write     = 1'b0;
    bus12.writedata = '0;
    model_reset();
    #1;
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ---------------- priming with DEADBEEF on ch0 ----------------
    rd(CTRL, d);
    check("ctrl_unprimed", d, 32'h0);
    for (int i = 0; i < 5; i++) begin
      rd(CHG, d);
      check("prime_change", d, 32'h0);
      check("prime_irq", {31'd0, irq}, 32'h0);
    end
    rd(CTRL, d);
    check("ctrl_primed", d, 32'h4);
    rd(0, d);
    check("data0_deadbeef", d, 32'hDEAD_BEEF);

    // Narrow-channel instance: zero-extension and undefined address.
    check("dw12_ch0", bus12.readdata, 32'h0000_0FFF);
    bus12.address = 3'd3;
    tick();
    check("dw12_ch3", bus12.readdata, 32'h0000_0ABC);
    bus12.address = 3'd7;
    tick();
    check("dw12_undef", bus12.readdata, 32'h0);

    // ---------------- register access vectors ----------------
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].we) begin
        wr(tbl[i].addr, tbl[i].wd);
      end else begin
        rd(tbl[i].addr, d);
        check($sformatf("vec%0d", i), d, tbl[i].exp);
      end
    end

    // ---------------- ch1 5->6 with mask 0010 ----------------
    in_port[1*DW +: DW] = 32'd5;
    for (int i = 0; i < 5; i++) tick();
    wr(CHG, 32'hF);
    wr(MSK, 32'h2);
    bus.address = AW'(CHG);
    tick();
    tick();
    check("ch1_irq_idle", {31'd0, irq}, 32'h0);
    in_port[1*DW +: DW] = 32'd6;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("ch1_irq_c%0d", k), {31'd0, irq}, (k == 4) ? 32'h1 : 32'h0);
    end
    check("ch1_change", bus.readdata, 32'h2);
    wr(CHG, 32'h2);
    check("w1c_irq_hold", {31'd0, irq}, 32'h1);
    bus.address = AW'(CHG);
    tick();
    check("w1c_irq_drop", {31'd0, irq}, 32'h0);
    check("w1c_change", bus.readdata, 32'h0);

    // ---------------- set beats W1C on ch2 ----------------
    wr(MSK, 32'h4);
    in_port[2*DW +: DW] = 32'd7;
    bus.address = AW'(CHG);
    for (int i = 0; i < 4; i++) tick();
    check("ch2_irq_first", {31'd0, irq}, 32'h1);
    in_port[2*DW +: DW] = 32'd8;
    tick();
    check("ch2_irq_a", {31'd0, irq}, 32'h1);
    tick();
    check("ch2_irq_b", {31'd0, irq}, 32'h1);
    wr(CHG, 32'h4);
    check("ch2_irq_c", {31'd0, irq}, 32'h1);
    rd(CHG, d);
    check("ch2_change_kept", d, 32'h4);
    check("ch2_irq_kept", {31'd0, irq}, 32'h1);
    wr(CHG, 32'hF);

    // ---------------- freeze + snap ----------------
    for (int k = 0; k < NC; k++) in_port[k*DW +: DW] = 32'(k + 1);
    for (int i = 0; i < 3; i++) tick();
    wr(CTRL, 32'h3);
    for (int k = 0; k < NC; k++) in_port[k*DW +: DW] = 32'd9;
    for (int i = 0; i < 3; i++) tick();
    for (int k = 0; k < NC; k++) begin
      rd(k, d);
      check($sformatf("frozen_ch%0d", k), d, 32'(k + 1));
    end
    wr(CTRL, 32'h0);
    for (int k = 0; k < NC; k++) begin
      rd(k, d);
      check($sformatf("live_ch%0d", k), d, 32'd9);
    end

    // ---------------- reset mid-burst ----------------
    wr(MSK, 32'hF);
    bus.address = AW'(CHG);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NC; k++) in_port[k*DW +: DW] = $urandom;
      tick();
    end
    check("burst_irq", {31'd0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    check("async_rst_readdata", bus.readdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    wr(MSK, 32'hF);
    bus.address = AW'(CHG);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NC; k++) in_port[k*DW +: DW] = $urandom;
      tick();
      check("reprime_change", bus.readdata, 32'h0);
      check("reprime_irq", {31'd0, irq}, 32'h0);
    end

    // ---------------- randomised phase ----------------
    for (int i = 0; i < 400; i++) begin
      int ch;
      int op;
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, NC - 1);
        in_port[ch*DW +: DW] = $urandom;
      end
      op            = $urandom_range(0, 9);
      bus.write     = 1'b0;
      bus.address   = AW'($urandom_range(0, 7));
      bus.writedata = $urandom;
      case (op)
        5: bus.write = 1'b1;
        6, 7: begin bus.write = 1'b1; bus.address = AW'(CHG); end
        8: begin bus.write = 1'b1; bus.address = AW'(MSK); end
        9: begin
          bus.write     = 1'b1;
          bus.address   = AW'(CTRL);
          bus.writedata = 32'($urandom_range(0, 3));
        end
        default: ;
      endcase
      tick();
    end
    bus.write = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pio_in_bank
`default_nettype wire

// File: doc/pio_in_bank.md
# pio_in_bank

Parametrised multi-channel Avalon-MM input PIO for the HPS lightweight bridge. It succeeds the single-word read-only input PIOs used for PID correction and encoder feedback. NUM_CH input words, each up to 32 bits, are synchronised into `clk`. The block adds per-channel change detection with a maskable interrupt, and a coherent snapshot mode so the HPS reads all channels from a single capture instant.

## Interface
Parameters:
- DATA_W, 32 — bits per channel, 1..32; readdata zero-extended above DATA_W.
- NUM_CH, 4 — channel count, 1..(2^ADDR_W − 3).
- ADDR_W, 3 — Avalon word-address width.
- SYNC_STAGES, 2 — synchroniser flops per bit; 0 = bypass (input already in `clk` domain).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; reset reset_n, asynchronous, active-low; clock clk.
- address  in  ADDR_W  word address.
- write  in  1  write strobe, single cycle per access.
- writedata  in  32  write data.
- readdata  out  32  registered read data, updated every cycle.
- in_port  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- irq  out  1  level interrupt, registered.

## Operation
Register map (word offsets):
- 0..NUM_CH−1 DATA[k] (RO): snapshot register if CTRL.freeze=1, else live synchronised value.
- NUM_CH CTRL (RW):
  - bit0 freeze (RW).
  - bit1 snap (write-1 strobe, reads 0).
  - bit2 primed (RO).
- NUM_CH+1 CHANGE (RW1C): bit k set when channel k synced value differs from its previous-cycle value.
- NUM_CH+2 IRQ_MASK (RW): bits [NUM_CH−1:0]; unused bits read 0.
- Any other address reads 0. Writes to RO or undefined addresses are ignored.

Behaviour:
- Synchroniser: SYNC_STAGES flops per bit, all reset to 0. No gray coding; multi-bit coherence is the producer's responsibility.
- Priming: after reset a counter runs SYNC_STAGES+1 cycles. During it, `prev` tracks synced data and CHANGE cannot set. `primed` goes 1 when the count ends. This prevents spurious flags from the reset-to-data transition.
- Change detect: once primed, CHANGE[k] is set when synced[k] ≠ prev[k].
- CHANGE set vs clear: if a set and a W1C clear hit the same bit in the same cycle, set wins.
- Snap: snap=1 loads all NUM_CH snapshot registers from the synced values present in that cycle, atomically. It works regardless of the freeze bit. Writing freeze and snap together is legal; the snapshot is taken at that edge.
- irq: registered |(CHANGE & IRQ_MASK).

## Timing
- readdata latency: 1 cycle. readdata is registered from the `address` sampled at each rising edge, with no read strobe. It reflects register state before any write in the same cycle.
- in_port → synced: SYNC_STAGES cycles.
- synced → CHANGE: +1 cycle.
- CHANGE → irq: +1 cycle.
- Total in_port edge → irq: SYNC_STAGES+2 cycles.
- W1C clear takes effect at the write edge. irq deasserts the following cycle unless a set occurred.
- Snapshot registers are visible on readdata 2 cycles after the snap write cycle (load edge, then read register).
- Reset values:
  - readdata = 0, irq = 0.
  - CTRL: freeze = 0, primed = 0.
  - CHANGE = 0, IRQ_MASK = 0, snapshots = 0.
  - sync/prev flops = 0, prime counter = 0.
- Asynchronous reset mid-operation clears everything immediately and restarts priming.

## Structure
- Shared package `pio_pkg`:
  - Register offset functions derived from NUM_CH (CTRL_OFS, CHANGE_OFS, MASK_OFS).
  - CTRL bit index constants.
  - Elaboration checks on DATA_W ≤ 32 and NUM_CH+3 ≤ 2^ADDR_W.
- Sub-module `pio_sync_bus`: width-parametrised N-stage synchroniser with asynchronous reset and SYNC_STAGES=0 bypass. Instantiated once over the full NUM_CH*DATA_W bus.
- Top level holds the prime counter, prev/snapshot/CHANGE/MASK registers, and the read mux.

## Test plan
- Reset with in_port=32'hDEADBEEF on ch0, SYNC_STAGES=2: CHANGE stays 0 and irq 0 throughout priming; primed reads 1 from cycle 3 onward; DATA0 reads 32'hDEADBEEF.
- Primed, IRQ_MASK=4'b0010, ch1 changes 5→6: CHANGE reads 4'b0010 and irq rises exactly 4 cycles after the in_port edge. A W1C of 32'h2 drops irq one cycle later.
- ch2 toggles on the same cycle a W1C of bit2 is written: CHANGE[2] remains 1 and irq stays asserted.
- freeze=1 with snap at values {1,2,3,4}, then inputs change to {9,9,9,9}: DATA reads return 1,2,3,4. With freeze=0, DATA reads return 9.
- Reads of address NUM_CH+3 (=7 for defaults), and DATA_W=12 with input 12'hFFF: readdata returns 0 and 32'h00000FFF respectively.
- Assert reset_n mid-burst of changes: irq and readdata go 0 asynchronously, and no CHANGE sets until priming completes again.
